// File: rtl/decode_pkg.sv
//------------------------------------------------------------------------------
// Module      : decode_pkg
// Description : Shared types and opcode classification for the decode front-end.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package decode_pkg;

  typedef enum logic [1:0] {
    IMM_2REG19 = 2'b00,
    IMM_1REG23 = 2'b01,
    IMM_BR27   = 2'b10,
    IMM_BRL27  = 2'b11
  } imm_type_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  // Only the two most significant opcode bits select the immediate format.
  function automatic imm_type_t classify(input logic [1:0] opcode_hi);
    imm_type_t t;
    t = IMM_2REG19;
    case (opcode_hi)
      2'b00: t = IMM_2REG19;
      2'b01: t = IMM_1REG23;
      2'b10: t = IMM_BR27;
      2'b11: t = IMM_BRL27;
      default: t = IMM_2REG19;
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_skid_buf.sv
//------------------------------------------------------------------------------
// Module      : decode_skid_buf
// Description : 1-entry buffer, or 2-entry skid FIFO when DECODE_SKID_EN is set.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_skid_buf
  import decode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  logic        pop,
  input  logic [31:0] din_instr,
  input  logic [1:0]  din_type,
  output logic [31:0] head_instr,
  output logic [1:0]  head_type,
  output logic        not_empty,
  output logic        push_ready
);

  occ_t        r_occ;
  occ_t        w_occ_nxt;
  logic [31:0] r_head_instr;
  logic [1:0]  r_head_type;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_occ <= OCC_EMPTY;
    else        r_occ <= w_occ_nxt;
  end

  always_comb begin
    w_occ_nxt = r_occ;
    if (flush) begin
      w_occ_nxt = OCC_EMPTY;
    end else begin
      case (r_occ)
        OCC_EMPTY: if (push) w_occ_nxt = OCC_ONE;
        OCC_ONE: begin
          if (pop && !push) w_occ_nxt = OCC_EMPTY;
`ifdef DECODE_SKID_EN
          else if (push && !pop) w_occ_nxt = OCC_TWO;
`endif
        end
        OCC_TWO: if (pop) w_occ_nxt = OCC_ONE;
        default: w_occ_nxt = OCC_EMPTY;
      endcase
    end
  end

`ifdef DECODE_SKID_EN
  logic [31:0] r_tail_instr;
  logic [1:0]  r_tail_type;
  logic        r_push_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_instr <= 32'd0;
      r_head_type  <= 2'b00;
      r_tail_instr <= 32'd0;
      r_tail_type  <= 2'b00;
    end else if (!flush) begin
      case (r_occ)
        OCC_EMPTY: if (push) begin
          r_head_instr <= din_instr;
          r_head_type  <= din_type;
        end
        OCC_ONE: begin
          if (push && pop) begin
            r_head_instr <= din_instr;
            r_head_type  <= din_type;
          end else if (push) begin
            r_tail_instr <= din_instr;
            r_tail_type  <= din_type;
          end
        end
        OCC_TWO: if (pop) begin
          r_head_instr <= r_tail_instr;
          r_head_type  <= r_tail_type;
        end
        default: ;
      endcase
    end
  end

  // Registered ready decouples d_ready from f_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_push_ready <= 1'b1;
    else        r_push_ready <= (w_occ_nxt != OCC_TWO);
  end

  assign push_ready = r_push_ready;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_instr <= 32'd0;
      r_head_type  <= 2'b00;
    end else if (!flush && push && ((r_occ == OCC_EMPTY) || pop)) begin
      r_head_instr <= din_instr;
      r_head_type  <= din_type;
    end
  end

  assign push_ready = (r_occ == OCC_EMPTY) || pop;
`endif

  assign head_instr = r_head_instr;
  assign head_type  = r_head_type;
  assign not_empty  = (r_occ != OCC_EMPTY);

endmodule

`default_nettype wire

// File: rtl/decode_imm_ctrl.sv
//------------------------------------------------------------------------------
// Module      : decode_imm_ctrl
// Description : Decode front-end: fetch buffer, immediate-type select, branch
//               bubbles. Optional 2-entry skid buffer via DECODE_SKID_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module decode_imm_ctrl
  import decode_pkg::*;
#(
  parameter int unsigned BRANCH_BUBBLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        f_valid,
  input  logic [31:0] f_instr,
  output logic        f_ready,
  input  logic        flush,
  output logic        d_valid,
  input  logic        d_ready,
  output logic [31:0] d_instr,
  output logic [26:0] ext_instr,
  output logic [1:0]  ext_immtype,
  output logic [2:0]  bubble_cnt
);

  localparam logic [2:0] c_bubbles = 3'(BRANCH_BUBBLES);

  logic        w_not_empty;
  logic        w_push_ready;
  logic        w_fetch;
  logic        w_issue;
  logic [1:0]  w_fetch_type;
  logic [31:0] w_head_instr;
  logic [1:0]  w_head_type;
  logic [2:0]  r_bubble_cnt;

  assign w_fetch_type = classify(f_instr[31:30]);
  assign w_fetch      = f_valid && w_push_ready;
  assign d_valid      = w_not_empty && (r_bubble_cnt == 3'd0);
  assign w_issue      = d_valid && d_ready;

  decode_skid_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (w_fetch),
    .pop        (w_issue),
    .din_instr  (f_instr),
    .din_type   (w_fetch_type),
    .head_instr (w_head_instr),
    .head_type  (w_head_type),
    .not_empty  (w_not_empty),
    .push_ready (w_push_ready)
  );

  // A flushed branch still issues but must not stall the refetched stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_bubble_cnt <= 3'd0;
    else if (flush)                     r_bubble_cnt <= 3'd0;
    else if (w_issue && w_head_type[1]) r_bubble_cnt <= c_bubbles;
    else if (r_bubble_cnt != 3'd0)      r_bubble_cnt <= r_bubble_cnt - 3'd1;
  end

  assign f_ready     = w_push_ready;
  assign d_instr     = w_head_instr;
  assign ext_instr   = w_head_instr[26:0];
  assign ext_immtype = w_head_type;
  assign bubble_cnt  = r_bubble_cnt;

endmodule

`default_nettype wire

// File: doc/decode_imm_ctrl.md
# decode_imm_ctrl

Decode-stage front-end controller that sits between the fetch pipeline register and the immediate Extender. It buffers fetched instructions behind a valid/ready handshake and classifies each one's opcode into the 2-bit immediate-type select. It drives the Extender's 27-bit instruction field and type select, and inserts a configurable number of bubbles after every branch-class instruction issued to execute.

## Interface
- BRANCH_BUBBLES, default 2: bubble cycles after a branch-class issue; legal range 0..7; 0 disables bubbling.
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- f_valid  input  1  fetch offers f_instr.
- f_instr  input  32  fetched instruction; opcode = [31:27], immediate field = [26:0].
- f_ready  output  1  controller accepts f_instr this cycle.
- flush  input  1  discard all buffered and incoming instructions.
- d_valid  output  1  head entry presented to execute.
- d_ready  input  1  execute consumes head entry.
- d_instr  output  32  head instruction.
- ext_instr  output  27  head instruction [26:0]; feeds the Extender Instr input.
- ext_immtype  output  2  head immediate type; feeds the Extender immediatetype input.
- bubble_cnt  output  3  remaining bubble cycles.

## Operation
- Fetch transfer: f_valid && f_ready at a rising edge.
- Issue transfer: d_valid && d_ready at a rising edge.
- Immediate-type classification is computed from f_instr[31:30] on fetch transfer and stored with the entry:
  - 00 gives 2'b00 (19-bit, two-register).
  - 01 gives 2'b01 (23-bit, one-register).
  - 10 gives 2'b10 (branch).
  - 11 gives 2'b11 (branch-and-link).
- Branch class is ext_immtype[1] == 1.
- Buffer state machine over occupancy:
  - EMPTY to ONE on a fetch transfer.
  - ONE to EMPTY on an issue transfer with no fetch transfer.
  - ONE to TWO on a fetch transfer with no issue transfer (skid configuration only).
  - TWO to ONE on an issue transfer.
  - Simultaneous fetch and issue transfers leave occupancy unchanged.
- Ordering is strict FIFO. The head entry is the oldest.
- d_valid = (occupancy != 0) && (bubble_cnt == 0).
- Bubbling:
  - An issue transfer of a branch-class entry loads bubble_cnt = BRANCH_BUBBLES.
  - Otherwise bubble_cnt decrements by 1 per cycle while nonzero; it saturates at 0.
  - Fetch transfers continue during bubbles whenever f_ready is high.
- Flush has highest priority. At the edge where flush = 1:
  - occupancy becomes 0 and bubble_cnt becomes 0.
  - Any simultaneous fetch transfer is discarded.
  - Any simultaneous issue transfer still counts for execute, but loads no bubbles.
- When d_valid = 0, d_instr, ext_instr and ext_immtype hold their last head value. Reset value is 0.

## Timing
- Reset values (rst_n low, asynchronous): d_valid 0, d_instr 0, ext_instr 0, ext_immtype 2'b00, bubble_cnt 0, occupancy EMPTY, f_ready 1.
- Latency: a fetch transfer at edge N gives d_valid = 1 in cycle N+1, absent bubbles.
- Throughput: one instruction per cycle with no branches and d_ready held high.
- All outputs except f_ready (see Configuration) are registered or decoded from registers only. There is no combinational path from f_* to d_*.
- Reset asserted mid-operation discards all entries immediately. The first fetch transfer is possible at the first edge after rst_n rises.

## Configuration
- DECODE_SKID_EN defined:
  - Two-entry skid buffer.
  - f_ready is a flop loaded with (next occupancy < 2).
  - There is no combinational path from d_ready to f_ready.
- DECODE_SKID_EN undefined:
  - Single entry; state TWO is unreachable.
  - f_ready = (occupancy == 0) || (d_valid && d_ready), combinational.

## Structure
- Shared package decode_pkg holds:
  - The imm_type_t enum: IMM_2REG19 = 2'b00, IMM_1REG23 = 2'b01, IMM_BR27 = 2'b10, IMM_BRL27 = 2'b11.
  - The occupancy state enum.
  - The classify function (opcode to imm_type_t).
- One sub-module, decode_skid_buf: the 1- or 2-entry FIFO storing {instr, immtype}. It owns the DECODE_SKID_EN variation.
- Bubble counter and flush logic live in the top module.

## Test plan
- Reset then stream: with d_ready = 1, push opcodes 00000, 01000, 00001 back-to-back. Required: d_valid from cycle 1, one issue per cycle, ext_immtype sequence 00, 01, 00, and ext_instr = f_instr[26:0] for each.
- Branch bubbles: with BRANCH_BUBBLES = 2, issue f_instr = 0x9000_0004 followed by a 19-bit-type instruction. Required: bubble_cnt reads 2, then 1, then 0; d_valid is low for exactly 2 cycles; ext_immtype 2'b10 precedes 2'b00.
- Backpressure (DECODE_SKID_EN defined): hold d_ready = 0 and offer 3 instructions. Required: 2 accepted, then f_ready = 0; after releasing d_ready, the entries issue in order with no loss or duplication.
- Flush mid-bubble: issue a branch, then assert flush during bubble 1 while f_valid = 1. Required: the next cycle has bubble_cnt 0 and d_valid 0, and the flushed fetch never appears on d_instr.
- Async reset with occupancy TWO: drop rst_n between edges. Required: d_valid, bubble_cnt and d_instr go to 0 immediately, and f_ready goes to 1.
- BRANCH_BUBBLES = 0: opcode 11000 issues back-to-back with the next instruction, and bubble_cnt stays 0.
